// File: rtl/ring_cnt_pkg.sv
// Shared constants and helpers for the ring/Johnson shift counter.
// Consumed by ring_johnson_counter and ring_cnt_legal_chk.
package ring_cnt_pkg;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  // Widest counter the home-pattern helper can describe.
  localparam int RING_CNT_MAX_W = 64;

  // Home pattern 0...01 for a counter of the given width. The result is
  // RING_CNT_MAX_W wide; callers keep the low WIDTH bits.
  function automatic logic [RING_CNT_MAX_W-1:0] ring_home(input int width);
    logic [RING_CNT_MAX_W-1:0] h;
    h = '0;
    for (int i = 0; i < RING_CNT_MAX_W; i++) begin
      h[i] = (i == 0) && (i < width);
    end
    return h;
  endfunction

endpackage

// File: rtl/ring_cnt_legal_chk.sv
// Combinational legality check for ring (one-hot) and Johnson
// (thermometer) counter states.
module ring_cnt_legal_chk
  import ring_cnt_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic             mode,
  output logic             legal
);

  // A Johnson state has at most one 0/1 boundary between adjacent bits.
  logic [WIDTH-2:0] edge_vec;

  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_edge
      assign edge_vec[gi] = q[gi] ^ q[gi+1];
    end
  endgenerate

  int unsigned ones_cnt;
  int unsigned edge_cnt;

  always_comb begin
    ones_cnt = 0;
    edge_cnt = 0;
    for (int i = 0; i < WIDTH; i++) begin
      ones_cnt = ones_cnt + 32'(q[i]);
    end
    for (int i = 0; i < WIDTH - 1; i++) begin
      edge_cnt = edge_cnt + 32'(edge_vec[i]);
    end
    if (mode == MODE_JOHNSON) begin
      legal = (edge_cnt <= 1);
    end else begin
      legal = (ones_cnt == 1);
    end
  end

endmodule

// File: rtl/ring_johnson_counter.sv
// Parametrised ring / Johnson shift counter with load, enable and wrap pulse.
// Define RING_CNT_SELF_CORRECT_EN to enable illegal-state detection and recovery.
module ring_johnson_counter
  import ring_cnt_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic             illegal
);

  localparam logic [RING_CNT_MAX_W-1:0] HOME_FULL = ring_home(WIDTH);
  localparam logic [WIDTH-1:0]          HOME      = HOME_FULL[WIDTH-1:0];

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic             wrap_reg;
  logic             wrap_next;
  logic [WIDTH-1:0] shift_val;
  logic             state_illegal;

`ifdef RING_CNT_SELF_CORRECT_EN
  logic state_legal;

  ring_cnt_legal_chk #(
    .WIDTH (WIDTH)
  ) u_legal_chk (
    .q     (q_reg),
    .mode  (mode),
    .legal (state_legal)
  );

  assign state_illegal = ~state_legal;
`else
  assign state_illegal = 1'b0;
`endif

  // One shift step under the currently sampled mode and direction.
  always_comb begin
    shift_val = q_reg;
    if (mode == MODE_JOHNSON) begin
      if (dir == DIR_DN) begin
        shift_val = {~q_reg[0], q_reg[WIDTH-1:1]};
      end else begin
        shift_val = {q_reg[WIDTH-2:0], ~q_reg[WIDTH-1]};
      end
    end else begin
      if (dir == DIR_DN) begin
        shift_val = {q_reg[0], q_reg[WIDTH-1:1]};
      end else begin
        shift_val = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
      end
    end
  end

  // Load beats count; a count step from an illegal state recovers to home
  // silently, so only a genuine shift back to home raises wrap.
  always_comb begin
    q_next    = q_reg;
    wrap_next = 1'b0;
    if (load) begin
      q_next = load_val;
    end else if (en) begin
      if (state_illegal) begin
        q_next = HOME;
      end else begin
        q_next    = shift_val;
        wrap_next = (shift_val == HOME);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_reg    <= HOME;
      wrap_reg <= 1'b0;
    end else begin
      q_reg    <= q_next;
      wrap_reg <= wrap_next;
    end
  end

  assign q       = q_reg;
  assign wrap    = wrap_reg;
  assign illegal = state_illegal;

endmodule

// File: tb/tb_ring_johnson_counter.sv
// Directed self-checking bench for ring_johnson_counter (WIDTH=4).
// Expectations adapt to whether RING_CNT_SELF_CORRECT_EN is defined.
module tb_ring_johnson_counter;

`ifdef RING_CNT_SELF_CORRECT_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       en;
  logic       mode;
  logic       dir;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] q;
  logic       wrap;
  logic       illegal;

  int n_checks;
  int n_fail;

  ring_johnson_counter #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .wrap     (wrap),
    .illegal  (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; return at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    $display("t=%0t en=%0b load=%0b mode=%0b dir=%0b q=%b wrap=%0b illegal=%0b",
             $time, en, load, mode, dir, q, wrap, illegal);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #3;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; mode = 1'b0; dir = 1'b0; load = 1'b0; load_val = 4'b0000;
    #12;
    n_checks++;
    if (q !== 4'b0001) begin n_fail++; $display("FAIL reset_q: got %b want 0001", q); end
    n_checks++;
    if (wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap: got %b want 0", wrap); end
    n_checks++;
    if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b want 0", illegal); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_ring_up();
    logic [3:0] exp_q [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic       exp_w [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    en = 1'b1; mode = 1'b0; dir = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (q !== exp_q[i] || wrap !== exp_w[i]) begin
        n_fail++;
        $display("FAIL ring_up[%0d]: got q=%b wrap=%b want q=%b wrap=%b", i, q, wrap, exp_q[i], exp_w[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_ring_down();
    logic [3:0] exp_q [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    logic       exp_w [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    load = 1'b1; load_val = 4'b0001; mode = 1'b0; dir = 1'b1;
    step();
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (q !== exp_q[i] || wrap !== exp_w[i]) begin
        n_fail++;
        $display("FAIL ring_down[%0d]: got q=%b wrap=%b want q=%b wrap=%b", i, q, wrap, exp_q[i], exp_w[i]);
      end
    end
    en = 1'b0; dir = 1'b0;
  endtask

  task automatic test_johnson_down();
    logic [3:0] exp_q [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                              4'b1111, 4'b0111, 4'b0011, 4'b0001};
    do_reset();
    en = 1'b1; mode = 1'b1; dir = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      n_checks++;
      if (q !== exp_q[i] || wrap !== (i == 7) || illegal !== 1'b0) begin
        n_fail++;
        $display("FAIL johnson_down[%0d]: got q=%b wrap=%b ill=%b want q=%b wrap=%b ill=0",
                 i, q, wrap, illegal, exp_q[i], (i == 7));
      end
    end
    en = 1'b0; mode = 1'b0; dir = 1'b0;
  endtask

  task automatic test_priority_hold();
    load = 1'b1; en = 1'b1; load_val = 4'b0100; mode = 1'b0; dir = 1'b0;
    step();
    n_checks++;
    if (q !== 4'b0100 || wrap !== 1'b0) begin
      n_fail++; $display("FAIL load_over_en: got q=%b wrap=%b want q=0100 wrap=0", q, wrap);
    end
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (q !== 4'b0100 || wrap !== 1'b0) begin
        n_fail++; $display("FAIL hold[%0d]: got q=%b wrap=%b want q=0100 wrap=0", i, q, wrap);
      end
    end
  endtask

  task automatic test_load_home();
    load = 1'b1; en = 1'b1; load_val = 4'b1000;
    step();
    load_val = 4'b0001;
    step();
    n_checks++;
    if (q !== 4'b0001 || wrap !== 1'b0) begin
      n_fail++; $display("FAIL load_home: got q=%b wrap=%b want q=0001 wrap=0", q, wrap);
    end
    load = 1'b0; en = 1'b0;
  endtask

  task automatic test_reset_mid();
    load = 1'b1; load_val = 4'b0100; mode = 1'b0; dir = 1'b0;
    step();
    load = 1'b0; en = 1'b1;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (q !== 4'b0001 || wrap !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_async: got q=%b wrap=%b want q=0001 wrap=0", q, wrap);
    end
    @(negedge clk);
    rst = 1'b1;
    step();
    n_checks++;
    if (q !== 4'b0010) begin
      n_fail++; $display("FAIL reset_mid_first_step: got q=%b want 0010", q);
    end
    // Reach a wrap, then reset: wrap must clear at once.
    load = 1'b1; load_val = 4'b1000;
    step();
    load = 1'b0;
    step();
    n_checks++;
    if (q !== 4'b0001 || wrap !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_wrap: got q=%b wrap=%b want q=0001 wrap=1", q, wrap);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (wrap !== 1'b0) begin
      n_fail++; $display("FAIL reset_clears_wrap: got wrap=%b want 0", wrap);
    end
    en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_self_correct();
    load = 1'b1; load_val = 4'b0110; mode = 1'b0; dir = 1'b0; en = 1'b0;
    step();
    n_checks++;
    if (q !== 4'b0110 || illegal !== SC) begin
      n_fail++; $display("FAIL sc_load: got q=%b illegal=%b want q=0110 illegal=%b", q, illegal, SC);
    end
    load = 1'b0; en = 1'b1;
    step();
    n_checks++;
    if (q !== (SC ? 4'b0001 : 4'b1100) || illegal !== 1'b0 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL sc_step: got q=%b illegal=%b wrap=%b want q=%b illegal=0 wrap=0",
               q, illegal, wrap, (SC ? 4'b0001 : 4'b1100));
    end
    en = 1'b0;
  endtask

  task automatic test_mode_switch();
    load = 1'b1; load_val = 4'b0111; mode = 1'b1; dir = 1'b0;
    step();
    load = 1'b0;
    n_checks++;
    if (q !== 4'b0111 || illegal !== 1'b0) begin
      n_fail++; $display("FAIL ms_johnson_legal: got q=%b illegal=%b want q=0111 illegal=0", q, illegal);
    end
    mode = 1'b0;
    #1;
    n_checks++;
    if (q !== 4'b0111 || illegal !== SC) begin
      n_fail++; $display("FAIL ms_switch: got q=%b illegal=%b want q=0111 illegal=%b", q, illegal, SC);
    end
    en = 1'b1;
    step();
    n_checks++;
    if (q !== (SC ? 4'b0001 : 4'b1110) || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL ms_step: got q=%b wrap=%b want q=%b wrap=0", q, wrap, (SC ? 4'b0001 : 4'b1110));
    end
    en = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_ring_up();
    test_ring_down();
    test_johnson_down();
    test_priority_hold();
    test_load_home();
    test_reset_mid();
    test_self_correct();
    test_mode_switch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ring_johnson_counter.md
# ring_johnson_counter

Parametrised shift-register counter generalising the fixed 4-bit ring counter. Supports ring (one-hot) and Johnson (twisted-ring) modes, both shift directions, enable, and parallel load. Provides a wrap pulse and optional illegal-state self-correction. Used as a sequencer/phase generator wherever the design needs a one-hot or thermometer-coded count.

## Interface
Parameters:
- WIDTH, 4, counter width in bits; must be at least 2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  count enable; one shift step per cycle while high.
- mode  in  1  0 = ring, 1 = Johnson.
- dir  in  1  0 = shift toward MSB, 1 = shift toward LSB.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value loaded into q when load is high.
- q  out  WIDTH  counter state.
- wrap  out  1  registered; high for exactly the cycle in which q has returned to the home pattern by a count step.
- illegal  out  1  combinational; q is not a legal pattern for the current mode.

## Operation
- Home pattern is H = 0…01 (bit 0 set). H is a legal state in both modes.
- Ring, dir=0: q ← {q[W-2:0], q[W-1]}. Ring, dir=1: q ← {q[0], q[W-1:1]}. Period is WIDTH.
- Johnson, dir=0: q ← {q[W-2:0], ~q[W-1]}. Johnson, dir=1: q ← {~q[0], q[W-1:1]}. Period is 2·WIDTH.
- Priority: reset > load > en > hold.
- load: q ← load_val and wrap ← 0, even if load_val == H.
- en=0 and load=0: q holds and wrap ← 0.
- wrap ← 1 only when a count step produces q_next == H.
- Legal states:
  - Ring: exactly one bit set.
  - Johnson: q is 0…01…1 or 1…10…0, including all-zeros and all-ones.
- mode and dir are sampled every step. A change takes effect on the next step without disturbing q. The state is checked against the new mode.

## Timing
- Reset (rst low, asynchronous) immediately sets q = H and wrap = 0. Release is synchronous to the next clk edge; the first step may occur on that edge if en=1.
- Latency: one cycle from en/load to q. illegal follows q combinationally, with zero latency.
- Reset mid-count overrides any in-flight step; no stale wrap.
- Ring, dir=0, WIDTH=4, en held: wrap is high on cycles 4, 8, 12…
- Johnson, WIDTH=4, en held: wrap is high on cycles 8, 16…

## Configuration
- RING_CNT_SELF_CORRECT_EN:
  - Defined: illegal is driven by the legality check. A count step taken from an illegal state sets q ← H and wrap ← 0 instead of shifting. load still accepts any value.
  - Undefined: illegal is tied to 0. Illegal states shift unchanged, following the normal shift rules forever.

## Structure
- Shared package ring_cnt_pkg holds:
  - Mode constants MODE_RING=1'b0 and MODE_JOHNSON=1'b1.
  - Direction constants DIR_UP=1'b0 and DIR_DN=1'b1.
  - A function returning the home pattern for a given width.
- Sub-module ring_cnt_legal_chk: combinational, parametrised by WIDTH. Inputs are q and mode; output is legal. It is instantiated only when RING_CNT_SELF_CORRECT_EN is defined.

## Test plan
- Ring up, WIDTH=4: reset, then en=1, mode=0, dir=0 → q = 0001, 0010, 0100, 1000, 0001. wrap is high only on the 0001 cycle after the fourth step.
- Johnson down, WIDTH=4: mode=1, dir=1 from reset → q = 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001. wrap is high on the eighth step.
- Priority and hold:
  - load=1, en=1, load_val=0100 → q = 0100, wrap = 0.
  - Then en=0 for 3 cycles → q stays 0100.
- Reset mid-count: ring at q=0100, rst driven low between edges → q = 0001 immediately. After release, the first step gives q = 0010.
- Self-correction, with RING_CNT_SELF_CORRECT_EN defined:
  - load 0110 in ring mode → illegal=1.
  - Next step → q = 0001, illegal = 0, wrap = 0.
  - Same stimulus without the macro → q = 1100, illegal = 0.
- Mode switch: Johnson at q=0111, switch to mode=0 → with the macro defined, illegal=1 and the next step gives q = 0001.
